// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo PWM bank.
// Defaults assume a 50 MHz clock: 20 ms frame, 0.5 ms .. 2.5 ms pulse.
package servo_pkg;

    localparam int FRAME_CYCLES_50M = 1000000;
    localparam int MIN_PULSE_50M    = 25000;
    localparam int STEP_CYCLES_50M  = 556;
    localparam int ANGLE_MAX        = 180;
    localparam int RESET_ANGLE      = 90;
    localparam int SLEW_STEP_DEF    = 2;

    typedef logic [7:0]  angle_t;
    typedef logic [16:0] pulse_t;
    typedef logic [19:0] frame_cnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: clamped (optionally slew-limited) shadow angle,
// pulse-length computation and the registered compare against the
// shared frame counter.
// Build option: define SERVO_SLEW_EN to limit the shadow angle change
// to SLEW_STEP degrees per frame.
import servo_pkg::*;

module servo_pwm_channel #(
    parameter int MIN_PULSE   = servo_pkg::MIN_PULSE_50M,
    parameter int STEP_CYCLES = servo_pkg::STEP_CYCLES_50M,
    parameter int ANGLE_MAX   = servo_pkg::ANGLE_MAX,
    parameter int RESET_ANGLE = servo_pkg::RESET_ANGLE,
    parameter int SLEW_STEP   = servo_pkg::SLEW_STEP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       run,
    input  frame_cnt_t cnt,
    input  angle_t     angle,
    output logic       pwm
);

    localparam angle_t MAX_A = angle_t'(ANGLE_MAX);
    localparam angle_t RST_A = angle_t'(RESET_ANGLE);

    // Reject configurations whose longest pulse cannot be represented
    // or whose minimum pulse would collapse the first compare cycle.
    if (MIN_PULSE < 2 || SLEW_STEP < 1 ||
        MIN_PULSE + ANGLE_MAX * STEP_CYCLES > 131071) begin : g_bad_cfg
        $error("servo_pwm_channel: invalid pulse/slew configuration");
    end

    angle_t tgt;
    angle_t shadow;
    angle_t shadow_next;
    pulse_t pulse;

    assign tgt = (angle > MAX_A) ? MAX_A : angle;

`ifdef SERVO_SLEW_EN
    localparam angle_t SLEW_A = angle_t'(SLEW_STEP);

    // Move toward the clamped target by at most SLEW_A degrees per load.
    always_comb begin
        shadow_next = tgt;
        if (tgt > shadow) begin
            if ((tgt - shadow) > SLEW_A) shadow_next = shadow + SLEW_A;
        end else begin
            if ((shadow - tgt) > SLEW_A) shadow_next = shadow - SLEW_A;
        end
    end
`else
    assign shadow_next = tgt;
`endif

    assign pulse = pulse_t'(MIN_PULSE) + pulse_t'(shadow) * pulse_t'(STEP_CYCLES);

    // Shadow only changes at frame boundaries; pwm is a registered compare.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= RST_A;
            pwm    <= 1'b0;
        end else begin
            if (load) shadow <= shadow_next;
            pwm <= run && (cnt < frame_cnt_t'(pulse));
        end
    end

endmodule

// File: rtl/servo_pwm_bank.sv
// Bank of NUM_CH hobby-servo PWM outputs sharing one frame counter.
// Angles are captured only at frame boundaries so a changing angle bus
// never glitches a pulse already in progress.
// Build option: SERVO_SLEW_EN enables per-frame slew limiting in each
// channel; frame timing is identical either way.
//
// state | meaning
// IDLE  | outputs low, waiting for en
// RUN   | frame counter running; a started frame always completes
import servo_pkg::*;

module servo_pwm_bank #(
    parameter int NUM_CH       = 8,
    parameter int FRAME_CYCLES = servo_pkg::FRAME_CYCLES_50M,
    parameter int MIN_PULSE    = servo_pkg::MIN_PULSE_50M,
    parameter int STEP_CYCLES  = servo_pkg::STEP_CYCLES_50M,
    parameter int ANGLE_MAX    = servo_pkg::ANGLE_MAX,
    parameter int RESET_ANGLE  = servo_pkg::RESET_ANGLE,
    parameter int SLEW_STEP    = servo_pkg::SLEW_STEP_DEF
) (
    input  logic                  FPGA_CLK1_50,
    input  logic                  reset,
    input  logic                  en,
    input  logic [8*NUM_CH-1:0]   angle,
    output logic [NUM_CH-1:0]     pwm,
    output logic                  frame_start,
    output logic                  busy
);

    localparam frame_cnt_t LAST = frame_cnt_t'(FRAME_CYCLES - 1);

    state_t     state;
    frame_cnt_t cnt;
    logic       load;
    logic       run;

    assign run  = (state == RUN);
    assign load = en && ((state == IDLE) || (cnt == LAST));

    // Frame sequencer: starts on en, restarts or stops only at frame end.
    always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en) begin
                        state       <= RUN;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (en) begin
                            frame_start <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_pwm_channel #(
            .MIN_PULSE   (MIN_PULSE),
            .STEP_CYCLES (STEP_CYCLES),
            .ANGLE_MAX   (ANGLE_MAX),
            .RESET_ANGLE (RESET_ANGLE),
            .SLEW_STEP   (SLEW_STEP)
        ) u_ch (
            .clk   (FPGA_CLK1_50),
            .reset (reset),
            .load  (load),
            .run   (run),
            .cnt   (cnt),
            .angle (angle[8*i +: 8]),
            .pwm   (pwm[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank with a shortened frame:
// 400-cycle frame, 25-cycle minimum pulse, 2 cycles per degree,
// so 0 deg -> 25, 90 deg -> 205, 180 deg and above -> 385 cycles.
module tb_servo_pwm_bank;

    localparam int NUM_CH = 4;
    localparam int F      = 400;
    localparam int MINP   = 25;
    localparam int STEP   = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                en = 1'b0;
    logic [8*NUM_CH-1:0] angle = '0;
    logic [NUM_CH-1:0]   pwm;
    logic                frame_start;
    logic                busy;

    int checks = 0;
    int failures = 0;
    int cap_hi [NUM_CH];
    int cap_rise [NUM_CH];
    int cap_fs;

    always #5 clk = ~clk;

    servo_pwm_bank #(
        .NUM_CH       (NUM_CH),
        .FRAME_CYCLES (F),
        .MIN_PULSE    (MINP),
        .STEP_CYCLES  (STEP),
        .ANGLE_MAX    (180),
        .RESET_ANGLE  (90),
        .SLEW_STEP    (2)
    ) dut (
        .FPGA_CLK1_50 (clk),
        .reset        (reset),
        .en           (en),
        .angle        (angle),
        .pwm          (pwm),
        .frame_start  (frame_start),
        .busy         (busy)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_frame_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2*F && !ok; i++) begin
            @(negedge clk);
            if (frame_start) ok = 1'b1;
        end
    endtask

    // Called at the negedge where frame_start is seen; records one frame.
    task automatic capture_frame(input int change_at, input logic [8*NUM_CH-1:0] new_angle,
                                 input int drop_at);
        for (int c = 0; c < NUM_CH; c++) begin
            cap_hi[c] = 0;
            cap_rise[c] = -1;
        end
        cap_fs = -1;
        for (int i = 1; i <= F; i++) begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (pwm[c]) begin
                    cap_hi[c]++;
                    if (cap_rise[c] < 0) cap_rise[c] = i;
                end
            end
            if (frame_start && cap_fs < 0) cap_fs = i;
            if (i == change_at) angle = new_angle;
            if (i == drop_at) en = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = 1'b1;
        angle = {$urandom, $urandom} & {(8*NUM_CH){1'b1}};
        repeat (4) @(negedge clk);
        checks++; if (pwm !== '0) begin failures++; $display("FAIL reset_pwm got=%h want=0", pwm); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b want=0", frame_start); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL release_fs got=%b want=1", frame_start); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL release_busy got=%b want=1", busy); end
        @(negedge clk);
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL fs_one_cycle got=%b want=0", frame_start); end
        checks++; if (pwm !== 4'hF) begin failures++; $display("FAIL first_rise got=%h want=f", pwm); end
    endtask

    task automatic test_pulse_widths();
        int exp_hi [NUM_CH] = '{25, 385, 385, 205};
        bit ok;
        angle = {8'd90, 8'd200, 8'd180, 8'd0};
        wait_frame_start(ok);
        checks++; if (!ok) begin failures++; $display("FAIL pw_wait_fs got=timeout want=frame_start"); end
        wait_frame_start(ok);
        checks++; if (!ok) begin failures++; $display("FAIL pw_wait_fs2 got=timeout want=frame_start"); end
        capture_frame(-1, '0, -1);
        for (int c = 0; c < NUM_CH; c++) begin
            checks++; if (cap_hi[c] !== exp_hi[c]) begin failures++; $display("FAIL pw_high ch%0d got=%0d want=%0d", c, cap_hi[c], exp_hi[c]); end
            checks++; if (cap_rise[c] !== 1) begin failures++; $display("FAIL pw_rise ch%0d got=%0d want=1", c, cap_rise[c]); end
        end
        checks++; if (cap_fs !== F) begin failures++; $display("FAIL pw_period got=%0d want=%0d", cap_fs, F); end
    endtask

    task automatic test_midframe_change();
        capture_frame(F/2, {8'd90, 8'd200, 8'd180, 8'd180}, -1);
        checks++; if (cap_hi[0] !== 25) begin failures++; $display("FAIL mid_keep ch0 got=%0d want=25", cap_hi[0]); end
        checks++; if (cap_fs !== F) begin failures++; $display("FAIL mid_period got=%0d want=%0d", cap_fs, F); end
        capture_frame(-1, '0, -1);
        checks++; if (cap_hi[0] !== 385) begin failures++; $display("FAIL mid_next ch0 got=%0d want=385", cap_hi[0]); end
        checks++; if (cap_rise[0] !== 1) begin failures++; $display("FAIL mid_rise ch0 got=%0d want=1", cap_rise[0]); end
    endtask

    task automatic test_en_drop();
        bit stray_pwm, stray_fs, stray_busy;
        capture_frame(-1, '0, 10);
        checks++; if (cap_hi[3] !== 205) begin failures++; $display("FAIL drop_complete ch3 got=%0d want=205", cap_hi[3]); end
        checks++; if (cap_hi[1] !== 385) begin failures++; $display("FAIL drop_complete ch1 got=%0d want=385", cap_hi[1]); end
        checks++; if (cap_fs !== -1) begin failures++; $display("FAIL drop_no_fs got=%0d want=-1", cap_fs); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_busy got=%b want=0", busy); end
        stray_pwm = 1'b0; stray_fs = 1'b0; stray_busy = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pwm !== '0) stray_pwm = 1'b1;
            if (frame_start !== 1'b0) stray_fs = 1'b1;
            if (busy !== 1'b0) stray_busy = 1'b1;
        end
        checks++; if (stray_pwm) begin failures++; $display("FAIL idle_pwm got=active want=low"); end
        checks++; if (stray_fs) begin failures++; $display("FAIL idle_fs got=pulse want=none"); end
        checks++; if (stray_busy) begin failures++; $display("FAIL idle_busy got=high want=low"); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        en = 1'b1;
        wait_frame_start(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rm_wait_fs got=timeout want=frame_start"); end
        repeat (100) @(negedge clk);
        checks++; if (pwm[1] !== 1'b1) begin failures++; $display("FAIL rm_pwm1_high got=%b want=1", pwm[1]); end
        reset = 1'b1;
        #1;
        checks++; if (pwm !== '0) begin failures++; $display("FAIL rm_async_pwm got=%h want=0", pwm); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_async_busy got=%b want=0", busy); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL rm_restart_fs got=%b want=1", frame_start); end
        capture_frame(-1, '0, -1);
        checks++; if (cap_hi[1] !== 385) begin failures++; $display("FAIL rm_fresh ch1 got=%0d want=385", cap_hi[1]); end
        checks++; if (cap_rise[1] !== 1) begin failures++; $display("FAIL rm_fresh_rise ch1 got=%0d want=1", cap_rise[1]); end
    endtask

    task automatic test_slew();
        bit ok;
        reset = 1'b1;
        en = 1'b1;
        angle = {8'd90, 8'd90, 8'd90, 8'd180};
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_frame_start(ok);
        checks++; if (!ok) begin failures++; $display("FAIL slew_wait_fs got=timeout want=frame_start"); end
        for (int k = 1; k <= 46; k++) begin
            capture_frame(-1, '0, -1);
            if (k == 1) begin
                checks++; if (cap_hi[0] !== 209) begin failures++; $display("FAIL slew_f1 ch0 got=%0d want=209", cap_hi[0]); end
                checks++; if (cap_hi[1] !== 205) begin failures++; $display("FAIL slew_f1 ch1 got=%0d want=205", cap_hi[1]); end
            end
            if (k == 2) begin
                checks++; if (cap_hi[0] !== 213) begin failures++; $display("FAIL slew_f2 ch0 got=%0d want=213", cap_hi[0]); end
            end
            if (k == 44) begin
                checks++; if (cap_hi[0] !== 381) begin failures++; $display("FAIL slew_f44 ch0 got=%0d want=381", cap_hi[0]); end
            end
            if (k == 45 || k == 46) begin
                checks++; if (cap_hi[0] !== 385) begin failures++; $display("FAIL slew_f%0d ch0 got=%0d want=385", k, cap_hi[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef SERVO_SLEW_EN
        test_slew();
`else
        test_pulse_widths();
        test_midframe_change();
        test_en_drop();
        test_reset_midframe();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
